// File: rtl/sample_mmio_bridge.sv
// sample_mmio_bridge: dmem-side bridge between the processor, the data RAM
// and the audio sample FIFO. Addresses below MMIO_BASE pass straight to RAM.
// The MMIO window exposes SAMPLE (push/count), STATUS (flags, clear, flush)
// and, when SAMPLE_UNDERRUN_CNT_EN is defined, a saturating underrun counter
// at BASE+2. With the macro undefined, BASE+2 reads as an unmapped word.
module sample_mmio_bridge #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   bufferQ [DEPTH];
  logic [AW-1:0] wrPtrQ, wrPtrD;
  logic [AW-1:0] rdPtrQ, rdPtrD;
  logic [CW-1:0] countQ, countD;
  logic          overflowQ, overflowD;

  logic [31:0]   offset;
  logic          isMmio, isSample, isStatus, isUnderrun;
  logic          push, pop, flush, clearOverflow, acceptPush, doWrite;
  logic          empty, full;

  assign ram_address = address_dmem;
  assign ram_data    = data;

  assign isMmio     = (address_dmem >= MMIO_BASE);
  assign offset     = address_dmem - MMIO_BASE;
  assign isSample   = isMmio && (offset == 32'd0);
  assign isStatus   = isMmio && (offset == 32'd1);
  assign isUnderrun = isMmio && (offset == 32'd2);

  assign ram_wren = wren && !isMmio;

  assign empty        = (countQ == '0);
  assign full         = (countQ == CW'(DEPTH));
  assign sample_valid = !empty;
  assign sample_out   = bufferQ[rdPtrQ];

  assign push          = wren && isSample;
  assign pop           = sample_valid && sample_ready;
  assign flush         = wren && isStatus && data[1];
  assign clearOverflow = wren && isStatus && data[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign acceptPush    = push && (!full || pop);

  // FIFO pointer/count/overflow next state; flush beats any same-cycle pop.
  always_comb begin
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    countD    = countQ;
    overflowD = overflowQ;
    doWrite   = 1'b0;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (acceptPush) begin
        doWrite = 1'b1;
        wrPtrD  = wrPtrQ + AW'(1);
      end
      if (pop) begin
        rdPtrD = rdPtrQ + AW'(1);
      end
      if (acceptPush && !pop) begin
        countD = countQ + CW'(1);
      end else if (pop && !acceptPush) begin
        countD = countQ - CW'(1);
      end
    end
    if (clearOverflow) begin
      overflowD = 1'b0;
    end
    if (push && full && !pop) begin
      overflowD = 1'b1;
    end
  end

  // FIFO control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
    end else begin
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
      overflowQ <= overflowD;
    end
  end

  // Sample storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (reset && doWrite) begin
      bufferQ[wrPtrQ] <= data[15:0];
    end
  end

`ifdef SAMPLE_UNDERRUN_CNT_EN
  logic [15:0] underrunQ, underrunD;
  logic        underrunClear;

  assign underrunClear = wren && isUnderrun;

  // Saturating count of edges where the codec wanted data but none was queued.
  always_comb begin
    underrunD = underrunQ;
    if (underrunClear) begin
      underrunD = '0;
    end else if (sample_ready && empty && (underrunQ != 16'hFFFF)) begin
      underrunD = underrunQ + 16'd1;
    end
  end

  // Underrun counter register; flush leaves it alone, reset clears it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      underrunQ <= '0;
    end else begin
      underrunQ <= underrunD;
    end
  end
`endif

  // Load data mux: RAM below the window, register file inside it.
  always_comb begin
    q_dmem = '0;
    if (!isMmio) begin
      q_dmem = ram_q;
    end else if (isSample) begin
      q_dmem = {{(32-CW){1'b0}}, countQ};
    end else if (isStatus) begin
      q_dmem = {29'd0, overflowQ, full, empty};
    end else if (isUnderrun) begin
`ifdef SAMPLE_UNDERRUN_CNT_EN
      q_dmem = {16'd0, underrunQ};
`else
      q_dmem = '0;
`endif
    end
  end

endmodule

// File: tb/tb_sample_mmio_bridge.sv
// Directed testbench for sample_mmio_bridge (DEPTH=16, MMIO_BASE=0x1000).
// Expectations are hand-derived; the BASE+2 checks follow whether
// SAMPLE_UNDERRUN_CNT_EN is defined for the build.
module tb_sample_mmio_bridge;

  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] SAMPLE   = BASE;
  localparam logic [31:0] STATUS   = BASE + 32'd1;
  localparam logic [31:0] UNDERRUN = BASE + 32'd2;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;

  logic [31:0] ramModel [256];
  logic [31:0] rd;
  int          testCount;
  int          failCount;

  sample_mmio_bridge #(.DEPTH(16), .MMIO_BASE(BASE)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Small behavioural data RAM with combinational read.
  always @(posedge clock) begin
    if (ram_wren) ramModel[ram_address[7:0]] <= ram_data;
  end
  assign ram_q = ramModel[ram_address[7:0]];

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one processor access for a single clock edge, then idle the bus.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] val,
                               input logic we);
    address_dmem = addr;
    data         = val;
    wren         = we;
    @(posedge clock);
    #1;
    wren = 1'b0;
  endtask

  // Combinational load from the bridge without advancing the clock.
  task automatic readReg(input logic [31:0] addr, output logic [31:0] val);
    address_dmem = addr;
    wren         = 1'b0;
    #1;
    val = q_dmem;
  endtask

  // Idle one clock edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    testCount    = 0;
    failCount    = 0;
    reset        = 1'b0;
    address_dmem = 32'd0;
    data         = 32'd0;
    wren         = 1'b0;
    sample_ready = 1'b0;

    applyStimulus(32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    readReg(STATUS, rd);
    checkOutput("reset_status", rd, 32'h1);
    readReg(SAMPLE, rd);
    checkOutput("reset_count", rd, 32'h0);
    checkOutput("reset_valid", {31'd0, sample_valid}, 32'h0);

    // RAM passthrough
    address_dmem = 32'h40;
    data         = 32'hDEAD_BEEF;
    wren         = 1'b1;
    #1;
    checkOutput("ram_wren_store", {31'd0, ram_wren}, 32'h1);
    checkOutput("ram_address", ram_address, 32'h40);
    checkOutput("ram_data", ram_data, 32'hDEAD_BEEF);
    tick();
    wren = 1'b0;
    readReg(32'h40, rd);
    checkOutput("ram_load", rd, 32'hDEAD_BEEF);
    checkOutput("ram_wren_load", {31'd0, ram_wren}, 32'h0);
    address_dmem = SAMPLE;
    data         = 32'h1234;
    wren         = 1'b1;
    #1;
    checkOutput("ram_wren_mmio", {31'd0, ram_wren}, 32'h0);
    tick();
    wren = 1'b0;
    readReg(SAMPLE, rd);
    checkOutput("mmio_push_count", rd, 32'h1);
    applyStimulus(STATUS, 32'h2, 1'b1);
    readReg(SAMPLE, rd);
    checkOutput("flush_count", rd, 32'h0);

    // FIFO order
    applyStimulus(SAMPLE, 32'h1, 1'b1);
    applyStimulus(SAMPLE, 32'h2, 1'b1);
    applyStimulus(SAMPLE, 32'hFFFF_0003, 1'b1);
    readReg(SAMPLE, rd);
    checkOutput("order_count", rd, 32'h3);
    readReg(STATUS, rd);
    checkOutput("order_status", rd, 32'h0);
    checkOutput("order_head1", {16'd0, sample_out}, 32'h1);
    sample_ready = 1'b1;
    tick();
    checkOutput("order_head2", {16'd0, sample_out}, 32'h2);
    tick();
    checkOutput("order_head3", {16'd0, sample_out}, 32'h3);
    tick();
    sample_ready = 1'b0;
    checkOutput("order_drained", {31'd0, sample_valid}, 32'h0);
    readReg(STATUS, rd);
    checkOutput("order_status_empty", rd, 32'h1);

    // Full / overflow
    for (int i = 0; i < 17; i++) applyStimulus(SAMPLE, 32'h100 + 32'(i), 1'b1);
    readReg(SAMPLE, rd);
    checkOutput("full_count", rd, 32'd16);
    readReg(STATUS, rd);
    checkOutput("full_status_ovf", rd, 32'h6);
    applyStimulus(STATUS, 32'h1, 1'b1);
    readReg(STATUS, rd);
    checkOutput("full_status_clr", rd, 32'h2);
    sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("full_drain%0d", i), {16'd0, sample_out}, 32'h100 + 32'(i));
      tick();
    end
    sample_ready = 1'b0;
    checkOutput("full_no_17th", {31'd0, sample_valid}, 32'h0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) applyStimulus(SAMPLE, 32'h200 + 32'(i), 1'b1);
    sample_ready = 1'b1;
    applyStimulus(SAMPLE, 32'h7777, 1'b1);
    sample_ready = 1'b0;
    readReg(SAMPLE, rd);
    checkOutput("pp_count", rd, 32'd16);
    readReg(STATUS, rd);
    checkOutput("pp_status", rd, 32'h2);
    sample_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checkOutput($sformatf("pp_drain%0d", i), {16'd0, sample_out}, 32'h200 + 32'(i));
      tick();
    end
    checkOutput("pp_7777", {16'd0, sample_out}, 32'h7777);
    tick();
    sample_ready = 1'b0;
    checkOutput("pp_empty", {31'd0, sample_valid}, 32'h0);

    // Reset and flush mid-stream
    for (int i = 0; i < 5; i++) applyStimulus(SAMPLE, 32'h300 + 32'(i), 1'b1);
    readReg(SAMPLE, rd);
    checkOutput("mid_count5", rd, 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    readReg(SAMPLE, rd);
    checkOutput("mid_reset_count", rd, 32'd0);
    checkOutput("mid_reset_valid", {31'd0, sample_valid}, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(SAMPLE, 32'h310 + 32'(i), 1'b1);
    checkOutput("mid_requeue_head", {16'd0, sample_out}, 32'h310);
    sample_ready = 1'b1;
    applyStimulus(STATUS, 32'h2, 1'b1);
    sample_ready = 1'b0;
    readReg(SAMPLE, rd);
    checkOutput("mid_flush_count", rd, 32'd0);
    checkOutput("mid_flush_valid", {31'd0, sample_valid}, 32'h0);
    applyStimulus(SAMPLE, 32'h3AB, 1'b1);
    readReg(SAMPLE, rd);
    checkOutput("mid_after_flush_count", rd, 32'd1);
    checkOutput("mid_after_flush_head", {16'd0, sample_out}, 32'h3AB);
    applyStimulus(STATUS, 32'h2, 1'b1);

    // Underrun counter / unmapped window
    applyStimulus(UNDERRUN, 32'h0, 1'b1);
    sample_ready = 1'b1;
    repeat (10) tick();
    sample_ready = 1'b0;
    readReg(UNDERRUN, rd);
`ifdef SAMPLE_UNDERRUN_CNT_EN
    checkOutput("underrun_10", rd, 32'd10);
    applyStimulus(UNDERRUN, 32'hABCD, 1'b1);
    readReg(UNDERRUN, rd);
    checkOutput("underrun_clr", rd, 32'd0);
`else
    checkOutput("underrun_unmapped", rd, 32'd0);
`endif
    readReg(BASE + 32'd5, rd);
    checkOutput("unmapped_read", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
